// File: rtl/rns_convertor_seq.sv
`default_nettype none
// ============================================================================
// Module   : rns_convertor_seq
// Purpose  : Iterative bidirectional binary <-> RNS converter over the
//            moduli set {2^K, 2^K-1, 2^K+1}. Forward conversion walks the
//            integer MSB-first, one bit per cycle; reverse conversion uses a
//            mixed-radix reconstruction built from shifts and conditional
//            subtracts only.
// Revision : 1.0 - initial release
// ============================================================================
module rns_convertor_seq #(
    parameter int K = 21
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [3*K:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_mode,
    output logic [3*K:0] out_data,
    output logic         out_err
);

    // Modulus constants, sized so the compare/subtract paths carry no slack.
    localparam logic [K:0]   c_m2    = {1'b0, {K{1'b1}}};                  // 2^K-1
    localparam logic [K+1:0] c_m3    = {2'b01, {(K-1){1'b0}}, 1'b1};       // 2^K+1
    localparam logic [K-1:0] c_ones  = {K{1'b1}};
    localparam logic [K:0]   c_two_k = {1'b1, {K{1'b0}}};                  // 2^K
    localparam int           c_cw    = $clog2(3*K);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FWD     = 3'd1,
        S_REV_D2  = 3'd2,
        S_REV_SH  = 3'd3,
        S_REV_ACC = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    // Shared datapath: r_a = r1/v1, r_b = r2/v2, r_c = r3/t/v3.
    logic [3*K-1:0]    r_x;
    logic [K-1:0]      r_a;
    logic [K-1:0]      r_b;
    logic [K:0]        r_c;
    logic [c_cw-1:0]   r_cnt;
    logic              r_err;
    logic              r_mode;

    // Forward step and doubling step for the 2^K+1 channel
    logic              w_shift_bit;
    logic [K-1:0]      w_r1_nxt;
    logic [K:0]        w_r2_dbl;
    logic [K-1:0]      w_r2_nxt;
    logic [K+1:0]      w_c_dbl;
    logic [K:0]        w_c_nxt;

    // Reverse digit extraction and accumulation
    logic [K-1:0]      w_r1_mod2;
    logic [K-1:0]      w_v2;
    logic [K:0]        w_a;
    logic [K:0]        w_t;
    logic [2*K-1:0]    w_mid;
    logic [3*K-1:0]    w_x;
    logic [K-1:0]      w_in_r2;
    logic [K:0]        w_in_r3;

    // Combinational arithmetic: every modular step is one conditional subtract.
    always_comb begin
        w_shift_bit = (r_state == S_FWD) ? r_x[3*K-1] : 1'b0;

        w_r1_nxt    = {r_a[K-2:0], w_shift_bit};
        w_r2_dbl    = {r_b, w_shift_bit};
        w_r2_nxt    = (w_r2_dbl >= c_m2) ? K'(w_r2_dbl - c_m2) : w_r2_dbl[K-1:0];
        w_c_dbl     = {r_c, w_shift_bit};
        w_c_nxt     = (w_c_dbl >= c_m3) ? (K+1)'(w_c_dbl - c_m3) : w_c_dbl[K:0];

        // r1 reduced into the 2^K-1 channel (all-ones aliases to zero)
        w_r1_mod2   = (r_a == c_ones) ? '0 : r_a;
        w_v2        = (r_b >= w_r1_mod2) ? K'(r_b - w_r1_mod2)
                                         : K'({1'b0, r_b} + c_m2 - {1'b0, w_r1_mod2});
        // a = (v1 - r3) mod 2^K+1, then t = (a - v2) mod 2^K+1
        w_a         = ({1'b0, r_a} >= r_c) ? (K+1)'({1'b0, r_a} - r_c)
                                           : (K+1)'({2'b00, r_a} + c_m3 - {1'b0, r_c});
        w_t         = (w_a >= {1'b0, w_v2}) ? (K+1)'(w_a - {1'b0, w_v2})
                                            : (K+1)'({1'b0, w_a} + c_m3 - {2'b00, w_v2});

        // v2 + (2^K-1)*v3 as (v3 << K) - v3 + v2; true value fits in 2K bits,
        // so dropping v3's top bit from the shifted term is harmless modulo 2^2K.
        w_mid       = {r_c[K-1:0], {K{1'b0}}} - {{(K-1){1'b0}}, r_c} + {{K{1'b0}}, r_b};
        w_x         = {w_mid, r_a};

        w_in_r2     = in_data[2*K-1:K];
        w_in_r3     = in_data[3*K:2*K];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = in_mode ? S_REV_D2 : S_FWD;
                end
            end
            S_FWD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_REV_D2: begin
                w_state_nxt = S_REV_SH;
            end
            S_REV_SH: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_REV_ACC;
                end
            end
            S_REV_ACC: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath registers and output holding registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_mode   <= 1'b0;
            out_data <= '0;
            out_err  <= 1'b0;
            out_mode <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mode <= in_mode;
                        if (!in_mode) begin
                            r_x   <= in_data[3*K-1:0];
                            r_a   <= '0;
                            r_b   <= '0;
                            r_c   <= '0;
                            // X >= M exactly when the upper 2K bits are all ones
                            r_err <= &in_data[3*K-1:K];
                            r_cnt <= c_cw'(3*K-1);
                        end else begin
                            r_a   <= in_data[K-1:0];
                            r_b   <= (w_in_r2 == c_ones) ? '0 : w_in_r2;
                            r_c   <= w_in_r3;
                            r_err <= (w_in_r3 > c_two_k);
                            r_cnt <= c_cw'(K-2);
                        end
                    end
                end
                S_FWD: begin
                    r_x   <= {r_x[3*K-2:0], 1'b0};
                    r_a   <= w_r1_nxt;
                    r_b   <= w_r2_nxt;
                    r_c   <= w_c_nxt;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        out_data <= {w_c_nxt, w_r2_nxt, w_r1_nxt};
                        out_err  <= r_err;
                        out_mode <= r_mode;
                    end
                end
                S_REV_D2: begin
                    r_b <= w_v2;
                    r_c <= w_t;
                end
                S_REV_SH: begin
                    r_c   <= w_c_nxt;
                    r_cnt <= r_cnt - 1'b1;
                end
                S_REV_ACC: begin
                    out_data <= r_err ? '0 : {1'b0, w_x};
                    out_err  <= r_err;
                    out_mode <= r_mode;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
